// File: rtl/dec_bit_packer.sv
// dec_bit_packer: reads the decoded hard-decision bits one per cycle from the
// 1-bit read port of the decode memory, packs them into bytes, then streams
// the bytes to the RS232 transmitter with a send/finish handshake.
module dec_bit_packer #(
    parameter int N_BITS    = 256,
    parameter int ADDR_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_finish,
    output logic              busy,
    output logic              done
);

    localparam int N_BYTES = N_BITS / 8;
    localparam int BI_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    // Counter is one bit wider than the address so N_BITS == 2^ADDR_W terminates cleanly
    localparam logic [ADDR_W:0]  CNT_END   = (ADDR_W + 1)'(N_BITS);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(N_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    // Bit position inside a byte for the low three address bits
    function automatic logic [2:0] bit_pos(input logic [2:0] a);
        if (LSB_FIRST != 0) begin
            return a;
        end else begin
            return 3'd7 - a;
        end
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tx_send_q, tx_send_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    // Read issued last cycle: its data is on rd_data this cycle
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        byte_buf_q [N_BYTES];
    logic [7:0]        byte_buf_d [N_BYTES];

    // Merge the returning memory bit into the byte buffer view used this cycle
    always_comb begin
        byte_buf_d  = byte_buf_q;
        pend_d      = rd_en_q;
        pend_addr_d = rd_addr_q;
        if (pend_q) begin
            byte_buf_d[pend_addr_q[ADDR_W-1:3]][bit_pos(pend_addr_q[2:0])] = rd_data;
        end else begin
            byte_buf_d = byte_buf_q;
        end
    end

    // Sequencing: read phase, drain of the last bit, then per-byte handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        tx_send_d  = tx_send_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {ADDR_W{1'b0}};
                    cnt_d     = (ADDR_W + 1)'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_END) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d     = cnt_q + (ADDR_W + 1)'(1);
                end
            end
            S_DRAIN: begin
                state_d    = S_SEND;
                byte_idx_d = {BI_W{1'b0}};
                tx_send_d  = 1'b1;
                tx_data_d  = byte_buf_d[{BI_W{1'b0}}];
            end
            S_SEND: begin
                if (tx_finish) begin
                    tx_send_d = 1'b0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = S_FIN;
                    end else begin
                        state_d    = S_GAP;
                        byte_idx_d = byte_idx_q + BI_W'(1);
                    end
                end else begin
                    tx_send_d = 1'b1;
                end
            end
            S_GAP: begin
                // One low cycle gives the transmitter a fresh request edge
                state_d   = S_SEND;
                tx_send_d = 1'b1;
                tx_data_d = byte_buf_d[byte_idx_q];
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                tx_send_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any transfer in flight
    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {(ADDR_W + 1){1'b0}};
            byte_idx_q  <= {BI_W{1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            tx_send_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Byte buffer storage; contents are meaningless until a readout fills them
    always_ff @(posedge ap_clk) begin
        byte_buf_q <= byte_buf_d;
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
